// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, reads instruction memory over req/ack, presents the
// instruction to decode and computes the next PC from redirects on retirement.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ins_valid,
    output logic [31:0] ins,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        ins_ready,
    input  logic        br_taken,
    input  logic        alu_to_pc,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc
);

    localparam int unsigned   CW    = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        FETCH,
        ISSUE,
        FAULT
    } state_t;

    state_t          state_q;
    logic            req_q;
    logic            ins_valid_q;
    logic [31:0]     ins_q;
    logic [31:0]     pc_q;
    logic            fault_q;
    logic [1:0]      cause_q;
    logic [31:0]     fault_pc_q;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     target_d;

    // jalr takes priority over a taken branch; the LSB of a jalr target is dropped
    always_comb begin
        if (alu_to_pc) begin
            target_d = alu_result & ~32'h1;
        end else if (br_taken) begin
            target_d = pc_q + imm;
        end else begin
            target_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            req_q       <= 1'b0;
            ins_valid_q <= 1'b0;
            ins_q       <= '0;
            pc_q        <= RESET_PC;
            fault_q     <= 1'b0;
            cause_q     <= '0;
            fault_pc_q  <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    // Leaving reset, req is raised one cycle later; acks seen while req is low are ignored
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (imem_ack) begin
                        ins_q       <= imem_rdata;
                        ins_valid_q <= 1'b1;
                        req_q       <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= ISSUE;
                    end else if (cnt_q == LIMIT) begin
                        req_q      <= 1'b0;
                        cnt_q      <= '0;
                        fault_q    <= 1'b1;
                        cause_q    <= 2'b10;
                        fault_pc_q <= pc_q;
                        state_q    <= FAULT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ISSUE: begin
                    if (ins_valid_q && ins_ready) begin
                        ins_valid_q <= 1'b0;
                        if (target_d[1:0] != 2'b00) begin
                            fault_q    <= 1'b1;
                            cause_q    <= 2'b01;
                            fault_pc_q <= target_d;
                            state_q    <= FAULT;
                        end else begin
                            pc_q    <= target_d;
                            req_q   <= 1'b1;
                            state_q <= FETCH;
                        end
                    end
                end
                FAULT: begin
                    req_q       <= 1'b0;
                    ins_valid_q <= 1'b0;
                end
                default: begin
                    req_q       <= 1'b0;
                    ins_valid_q <= 1'b0;
                    state_q     <= FAULT;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign ins_valid   = ins_valid_q;
    assign ins         = ins_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign fault_pc    = fault_pc_q;

endmodule
